// File: rtl/ppu_pixel_capture_if.sv
// Pixel capture bus: PPU pixel stream in, framebuffer write port out.
// The slave modport is the capture block; the master drives pixels and observes writes.
interface ppu_pixel_capture_if;
    logic [1:0]  PX_IN;
    logic        PX_valid;
    logic [1:0]  PPU_MODE;
    logic        LCD_ON;
    logic [7:0]  BGP;
    logic        FB_WE;
    logic [14:0] FB_ADDR;
    logic [1:0]  FB_DATA;
    logic        FB_BANK;
    logic        FRAME_DONE;
    logic        OVERRUN;

    modport master (
        output PX_IN, PX_valid, PPU_MODE, LCD_ON, BGP,
        input  FB_WE, FB_ADDR, FB_DATA, FB_BANK, FRAME_DONE, OVERRUN
    );

    modport slave (
        input  PX_IN, PX_valid, PPU_MODE, LCD_ON, BGP,
        output FB_WE, FB_ADDR, FB_DATA, FB_BANK, FRAME_DONE, OVERRUN
    );
endinterface

// File: rtl/ppu_pixel_capture.sv
// Captures the PPU pixel stream into a double-buffered 160x144 framebuffer.
// Define PIXEL_PALETTE_MAP_EN to map pixels through BGP before writing.
module ppu_pixel_capture (
    input  logic                  clk,
    input  logic                  rst,
    ppu_pixel_capture_if.slave    bus
);

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        CAPTURE = 2'd1,
        BLANK   = 2'd2
    } state_t;

    localparam logic [1:0] M_HBLANK = 2'd0;
    localparam logic [1:0] M_VBLANK = 2'd1;
    localparam logic [1:0] M_SCAN   = 2'd2;
    localparam logic [1:0] M_DRAW   = 2'd3;

    state_t      r_state, w_state_nxt;
    logic [1:0]  r_prev_mode;
    logic [7:0]  r_row, w_row_nxt;
    logic [7:0]  r_col, w_col_nxt;
    logic        r_we, w_we_nxt;
    logic [14:0] r_addr, w_addr_nxt;
    logic [1:0]  r_data, w_data_nxt;
    logic        r_bank, w_bank_nxt;
    logic        r_done, w_done_nxt;
    logic        r_ovr, w_ovr_nxt;

    logic        w_vb_entry;
    logic        w_scan_entry;
    logic        w_line_end;
    logic        w_in_range;
    logic [14:0] w_pix_addr;
    logic [1:0]  w_shade;

    assign w_vb_entry   = (bus.PPU_MODE == M_VBLANK) && (r_prev_mode != M_VBLANK);
    assign w_scan_entry = (bus.PPU_MODE == M_SCAN) && (r_prev_mode != M_SCAN);
    assign w_line_end   = (r_prev_mode == M_DRAW) && (bus.PPU_MODE == M_HBLANK);
    assign w_in_range   = (r_col < 8'd160) && (r_row < 8'd144);

    // row*160 as row*128 + row*32, kept at full 15-bit width
    assign w_pix_addr = {r_row, 7'b0}
                      + {2'b0, r_row, 5'b0}
                      + {7'b0, r_col};

`ifdef PIXEL_PALETTE_MAP_EN
    assign w_shade = bus.BGP[{bus.PX_IN, 1'b0} +: 2];
`else
    logic w_bgp_unused;
    assign w_bgp_unused = ^bus.BGP;
    assign w_shade      = bus.PX_IN;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= SYNC;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_bank_nxt  = r_bank;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = r_ovr;
        if (!bus.LCD_ON) begin
            w_state_nxt = SYNC;
            if (r_state != SYNC) begin
                w_ovr_nxt = 1'b0;
            end
        end else begin
            case (r_state)
                SYNC: begin
                    if (w_vb_entry) begin
                        w_state_nxt = CAPTURE;
                        w_row_nxt   = 8'd0;
                        w_col_nxt   = 8'd0;
                    end
                end
                CAPTURE: begin
                    if (bus.PX_valid) begin
                        if (w_in_range) begin
                            w_we_nxt   = 1'b1;
                            w_addr_nxt = w_pix_addr;
                            w_data_nxt = w_shade;
                            w_col_nxt  = r_col + 8'd1;
                        end else begin
                            w_ovr_nxt = 1'b1;
                        end
                    end
                    // line end overrides the column step; the pixel above used pre-increment row/col
                    if (w_line_end) begin
                        w_col_nxt = 8'd0;
                        w_row_nxt = (r_row == 8'd144) ? 8'd144 : r_row + 8'd1;
                    end
                    if (w_vb_entry) begin
                        w_state_nxt = BLANK;
                        w_done_nxt  = 1'b1;
                        w_bank_nxt  = ~r_bank;
                    end
                end
                BLANK: begin
                    if (w_scan_entry) begin
                        w_state_nxt = CAPTURE;
                        w_row_nxt   = 8'd0;
                        w_col_nxt   = 8'd0;
                    end
                end
                default: begin
                    w_state_nxt = SYNC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_prev_mode <= 2'd0;
            r_row       <= 8'd0;
            r_col       <= 8'd0;
            r_we        <= 1'b0;
            r_addr      <= 15'd0;
            r_data      <= 2'd0;
            r_bank      <= 1'b0;
            r_done      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_prev_mode <= bus.PPU_MODE;
            r_row       <= w_row_nxt;
            r_col       <= w_col_nxt;
            r_we        <= w_we_nxt;
            r_addr      <= w_addr_nxt;
            r_data      <= w_data_nxt;
            r_bank      <= w_bank_nxt;
            r_done      <= w_done_nxt;
            r_ovr       <= w_ovr_nxt;
        end
    end

    assign bus.FB_WE      = r_we;
    assign bus.FB_ADDR    = r_addr;
    assign bus.FB_DATA    = r_data;
    assign bus.FB_BANK    = r_bank;
    assign bus.FRAME_DONE = r_done;
    assign bus.OVERRUN    = r_ovr;

endmodule

// File: tb/tb_ppu_pixel_capture.sv
// Scoreboard bench for ppu_pixel_capture: expected writes queued at drive time,
// popped and compared when FB_WE is seen.
module tb_ppu_pixel_capture;

    logic clk;
    logic rst;

    ppu_pixel_capture_if bus ();

    ppu_pixel_capture dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [1:0]  data;
    } wr_t;

    wr_t q[$];
    int  n_chk = 0;
    int  n_fail = 0;
    int  frame_cnt = 0;
    int  wr_cnt = 0;
    int  last_addr = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] shade(input logic [1:0] px, input logic [7:0] bgp);
        logic [7:0] s;
`ifdef PIXEL_PALETTE_MAP_EN
        s = bgp >> (2 * px);
`else
        s = {6'b0, px} | (bgp & 8'h00);
`endif
        return s[1:0];
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.FRAME_DONE) frame_cnt++;
            if (bus.FB_WE) begin
                wr_cnt++;
                if (q.size() == 0) begin
                    chk("spurious_we", 32'(bus.FB_WE), 32'd0);
                end else begin
                    wr_t e;
                    e = q.pop_front();
                    chk("fb_addr", 32'(bus.FB_ADDR), 32'(e.addr));
                    chk("fb_data", 32'(bus.FB_DATA), 32'(e.data));
                    last_addr = int'(bus.FB_ADDR);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mode(input logic [1:0] m);
        bus.PPU_MODE = m;
        step();
    endtask

    task automatic send_px(input logic [1:0] px, input bit wr, input int addr);
        wr_t e;
        bus.PX_IN    = px;
        bus.PX_valid = 1'b1;
        if (wr) begin
            e.addr = 15'(addr);
            e.data = shade(px, bus.BGP);
            q.push_back(e);
        end
        step();
    endtask

    task automatic idle(input int n);
        bus.PX_valid = 1'b0;
        repeat (n) step();
    endtask

    int w0;

    initial begin
        rst          = 1'b0;
        bus.PX_IN    = 2'd0;
        bus.PX_valid = 1'b0;
        bus.PPU_MODE = 2'd0;
        bus.LCD_ON   = 1'b0;
        bus.BGP      = 8'hE4;
        #22;
        chk("rst_we", 32'(bus.FB_WE), 0);
        chk("rst_addr", 32'(bus.FB_ADDR), 0);
        chk("rst_data", 32'(bus.FB_DATA), 0);
        chk("rst_bank", 32'(bus.FB_BANK), 0);
        chk("rst_done", 32'(bus.FRAME_DONE), 0);
        chk("rst_ovr", 32'(bus.OVERRUN), 0);
        step();
        rst = 1'b1;
        bus.LCD_ON = 1'b1;
        step();

        // basic burst: sync on V_BLANK entry, 8 pixels on row 0
        mode(2'd2);
        mode(2'd1);
        mode(2'd2);
        chk("sync_no_done", 32'(frame_cnt), 0);
        chk("sync_no_bank", 32'(bus.FB_BANK), 0);
        bus.PPU_MODE = 2'd3;
        w0 = wr_cnt;
        for (int i = 0; i < 8; i++) send_px(2'(i % 4), 1'b1, i);
        idle(2);
        chk("burst_writes", 32'(wr_cnt - w0), 8);
        chk("burst_q", 32'(q.size()), 0);
        mode(2'd0);

        // row 1: 161 pixels, the last is dropped
        bus.PPU_MODE = 2'd3;
        w0 = wr_cnt;
        for (int i = 0; i < 161; i++) send_px(2'($urandom_range(3)), i < 160, 160 + i);
        idle(2);
        chk("ovr_writes", 32'(wr_cnt - w0), 160);
        chk("ovr_set", 32'(bus.OVERRUN), 1);
        mode(2'd0);
        idle(5);
        chk("ovr_sticky", 32'(bus.OVERRUN), 1);

        // row 2: LCD off at col 50
        bus.PPU_MODE = 2'd3;
        w0 = wr_cnt;
        for (int i = 0; i < 50; i++) send_px(2'($urandom_range(3)), 1'b1, 320 + i);
        bus.LCD_ON = 1'b0;
        for (int i = 0; i < 6; i++) send_px(2'($urandom_range(3)), 1'b0, 0);
        idle(2);
        chk("lcdoff_writes", 32'(wr_cnt - w0), 50);
        chk("lcdoff_ovr_clr", 32'(bus.OVERRUN), 0);
        chk("lcdoff_no_done", 32'(frame_cnt), 0);

        // restore: pixels in SYNC dropped, first V_BLANK entry silent
        bus.LCD_ON = 1'b1;
        for (int i = 0; i < 4; i++) send_px(2'd1, 1'b0, 0);
        bus.PX_valid = 1'b0;
        mode(2'd0);
        mode(2'd1);
        idle(2);
        chk("resync_no_done", 32'(frame_cnt), 0);
        chk("resync_bank", 32'(bus.FB_BANK), 0);
        chk("resync_ovr", 32'(bus.OVERRUN), 0);

        // full 144x160 frame
        mode(2'd2);
        w0 = wr_cnt;
        for (int r = 0; r < 144; r++) begin
            bus.PPU_MODE = 2'd3;
            for (int c = 0; c < 160; c++) send_px(2'($urandom_range(3)), 1'b1, r * 160 + c);
            bus.PX_valid = 1'b0;
            mode(2'd0);
        end
        idle(1);
        chk("frame_writes", 32'(wr_cnt - w0), 23040);
        chk("frame_last_addr", 32'(last_addr), 23039);
        mode(2'd1);
        idle(2);
        chk("frame_done", 32'(frame_cnt), 1);
        chk("frame_bank", 32'(bus.FB_BANK), 1);
        chk("frame_ovr", 32'(bus.OVERRUN), 0);

        // BLANK drops pixels silently, then SCAN starts a new frame at 0
        w0 = wr_cnt;
        for (int i = 0; i < 5; i++) send_px(2'd2, 1'b0, 0);
        idle(2);
        chk("blank_writes", 32'(wr_cnt - w0), 0);
        chk("blank_ovr", 32'(bus.OVERRUN), 0);
        bus.BGP = 8'h1B;
        mode(2'd2);
        bus.PPU_MODE = 2'd3;
        for (int i = 0; i < 4; i++) send_px(2'(i), 1'b1, i);
        idle(2);
        chk("bgp_q", 32'(q.size()), 0);
        mode(2'd0);
        mode(2'd1);
        idle(2);
        chk("short_done", 32'(frame_cnt), 2);
        chk("short_bank", 32'(bus.FB_BANK), 0);

        // async reset in the middle of a burst
        bus.BGP = 8'hE4;
        mode(2'd2);
        bus.PPU_MODE = 2'd3;
        for (int i = 0; i < 161; i++) send_px(2'($urandom_range(3)), i < 160, i);
        bus.PX_valid = 1'b0;
        mode(2'd0);
        bus.PPU_MODE = 2'd3;
        for (int i = 0; i < 20; i++) send_px(2'($urandom_range(3)), 1'b1, 160 + i);
        chk("pre_rst_ovr", 32'(bus.OVERRUN), 1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_we", 32'(bus.FB_WE), 0);
        chk("arst_addr", 32'(bus.FB_ADDR), 0);
        chk("arst_ovr", 32'(bus.OVERRUN), 0);
        chk("arst_bank", 32'(bus.FB_BANK), 0);
        q.delete();
        bus.PX_valid = 1'b0;
        step();
        rst = 1'b1;
        idle(3);
        chk("post_rst_we", 32'(bus.FB_WE), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
